regfile8: RTL
=============

// Module: regfile8
//
// PURPOSE
// - 8-entry x WIDTH register bank; upstream source of the 8:1 bit-select mux trees in the datapath.
// - One synchronous write port, two independent registered read ports.
// - Reads return data one clock after request; read outputs hold between requests.
// - Sits between writeback (write port) and operand select (read ports).
//
// PARAMETERS
// - WIDTH     32  data bits per entry
// - ZERO_REG  0   1: entry 0 reads 0 always and ignores writes; 0: entry 0 is a normal register
//
// PORTS
// - clk     in   1      single clock; all state updates on rising edge
// - rst     in   1      synchronous, active-high reset
// - we      in   1      write enable
// - waddr   in   3      write entry index
// - wdata   in   WIDTH  write data
// - re0     in   1      read-port-0 request
// - raddr0  in   3      read-port-0 entry index
// - rdata0  out  WIDTH  read-port-0 data, registered
// - re1     in   1      read-port-1 request
// - raddr1  in   3      read-port-1 entry index
// - rdata1  out  WIDTH  read-port-1 data, registered
//
// BEHAVIOUR
// - Reset: rst=1 at an edge clears all 8 entries, rdata0 and rdata1 to 0. rst overrides we/re0/re1 in the same cycle.
// - Reset mid-operation: a write or read presented with rst=1 is discarded. The first cycle after rst=0 behaves normally.
// - Write: we=1 at an edge -> entry[waddr] <= wdata. With ZERO_REG=1 and waddr=0, the write is dropped.
// - Read latency: 1 cycle. rek=1 at edge N -> rdatak equals the selected entry value from edge N onward.
// - Read hold: rek=0 -> rdatak keeps its previous value. Later writes to that entry do not update rdatak.
// - ZERO_REG=1: a read of entry 0 returns 0 regardless of memory contents.
// - Both ports may read the same entry in one cycle; each gets identical data.
// - Same-edge write/read collision (we=1, rek=1, waddr==raddrk): governed by REGFILE_BYPASS_EN.
// - Collision against a dropped write (ZERO_REG=1, addr 0) always returns 0.
// - Address wrap: 3-bit indices cover all 8 entries, so no out-of-range case exists.
// - No combinational path from any input to rdata0/rdata1.
//
// CONFIGURATION
// - Macro REGFILE_BYPASS_EN.
// - Defined: a colliding read returns wdata, i.e. the new value.
// - Undefined: a colliding read returns the entry's value before the write. The write still lands, so a re-read on the next cycle returns wdata.
// - Non-colliding behaviour is identical in both builds.
//
// TESTING
// - Reset: write 0xDEADBEEF to all entries; assert rst for 1 cycle; read entries 0..7 on both ports -> all 0x00000000.
// - Write/read: write entry3=0x12345678 and entry5=0xCAFEF00D; next cycle raddr0=3, raddr1=5 -> 0x12345678 / 0xCAFEF00D one cycle later.
// - Hold: read entry3 (0x12345678), then re0=0 and write entry3=0x1; rdata0 stays 0x12345678 until re0 is reasserted, then reads 0x1.
// - Collision: entry2=0xAAAA0000; same edge we=1, waddr=2, wdata=0x5555FFFF, re0=1, raddr0=2.
//   Expected rdata0: 0x5555FFFF with REGFILE_BYPASS_EN, 0xAAAA0000 without.
//   Next-cycle read of entry2 -> 0x5555FFFF in both builds.
// - ZERO_REG=1: write entry0=0xFFFFFFFF -> both ports read 0. Same-edge collision on entry 0 -> 0.
// - Reset priority: rst=1 together with we=1, waddr=4, wdata=0x77 and re1=1, raddr1=4 -> rdata1=0, and entry4 reads 0 afterward.

Source files
------------

// File: rtl/regfile8.sv
// rtl/regfile8.sv - 8-entry x WIDTH register bank, one write port, two registered read ports
// Optional macro REGFILE_BYPASS_EN: a same-edge colliding read returns the incoming write data.
module regfile8 #(
    parameter int WIDTH    = 32,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [2:0]       waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re0,
    input  logic [2:0]       raddr0,
    output logic [WIDTH-1:0] rdata0,
    input  logic             re1,
    input  logic [2:0]       raddr1,
    output logic [WIDTH-1:0] rdata1
);

    logic [WIDTH-1:0] mem_q [8];
    logic [WIDTH-1:0] mem_d [8];
    logic [WIDTH-1:0] rdata0_q, rdata0_d;
    logic [WIDTH-1:0] rdata1_q, rdata1_d;
    logic             wr_en;
    logic             zero0, zero1;
    logic             bypass0, bypass1;

    // Writes to entry 0 are dropped when it is hardwired to zero.
    assign wr_en = we && !(ZERO_REG && (waddr == 3'd0));
    assign zero0 = ZERO_REG && (raddr0 == 3'd0);
    assign zero1 = ZERO_REG && (raddr1 == 3'd0);

`ifdef REGFILE_BYPASS_EN
    assign bypass0 = wr_en && (waddr == raddr0);
    assign bypass1 = wr_en && (waddr == raddr1);
`else
    assign bypass0 = 1'b0;
    assign bypass1 = 1'b0;
`endif

    always_comb begin
        mem_d    = mem_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (wr_en) begin
            mem_d[waddr] = wdata;
        end
        if (re0) begin
            if (zero0)        rdata0_d = '0;
            else if (bypass0) rdata0_d = wdata;
            else              rdata0_d = mem_q[raddr0];
        end
        if (re1) begin
            if (zero1)        rdata1_d = '0;
            else if (bypass1) rdata1_d = wdata;
            else              rdata1_d = mem_q[raddr1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[i] <= '0;
            end
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            mem_q    <= mem_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule
